// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD subtract datapath.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int BCD_BASE    = 10;
    localparam int BCD_DIGIT_W = 4;

    function automatic logic is_bcd_digit(input logic [BCD_DIGIT_W-1:0] nib);
        return nib < BCD_DIGIT_W'(BCD_BASE);
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One-digit BCD subtract slice: x - y - borrow_in with decimal correction.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] x,
    input  logic [BCD_DIGIT_W-1:0] y,
    input  logic                   borrow_in,
    output logic [BCD_DIGIT_W-1:0] digit,
    output logic                   borrow_out
);

    logic signed [BCD_DIGIT_W:0] diff;
    logic signed [BCD_DIGIT_W:0] fixed;

    // 5-bit signed covers -16..15, enough for any pair of 4-bit nibbles.
    always_comb begin
        diff  = $signed({1'b0, x}) - $signed({1'b0, y})
              - $signed({{BCD_DIGIT_W{1'b0}}, borrow_in});
        fixed = diff + $signed((BCD_DIGIT_W+1)'(BCD_BASE));
        if (diff < 0) begin
            digit      = fixed[BCD_DIGIT_W-1:0];
            borrow_out = 1'b1;
        end else begin
            digit      = diff[BCD_DIGIT_W-1:0];
            borrow_out = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial |A-B| with sign, LSD first; ten's-complement fixup pass when A<B.
// Optional input nibble validation under BCD_SUB_INPUT_CHECK_EN.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] result,
    output logic                          neg,
    output logic                          err
);

    localparam int W     = BCD_DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                 state, state_n;
    logic [W-1:0]           a_q, b_q, r_q;
    logic                   borrow_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   busy_q, done_q, neg_q;

    logic [BCD_DIGIT_W-1:0] x, y, dig;
    logic                   dig_borrow;
    logic                   last;
    logic                   bad;
    logic [W-1:0]           r_shift;

    // FIX reuses the slice as 0 - r_i - borrow, negating the complement.
    assign x    = (state == FIX) ? '0 : a_q[BCD_DIGIT_W-1:0];
    assign y    = (state == FIX) ? r_q[BCD_DIGIT_W-1:0] : b_q[BCD_DIGIT_W-1:0];
    assign last = (idx_q == IDX_W'(DIGITS-1));

    bcd_digit_sub u_digit_sub (
        .x          (x),
        .y          (y),
        .borrow_in  (borrow_q),
        .digit      (dig),
        .borrow_out (dig_borrow)
    );

    // New digit enters at the top; after DIGITS shifts the word is in order.
    assign r_shift = (r_q >> BCD_DIGIT_W) | (W'(dig) << (W - BCD_DIGIT_W));

`ifdef BCD_SUB_INPUT_CHECK_EN
    logic err_q;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd_digit(a[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
                !is_bcd_digit(b[i*BCD_DIGIT_W +: BCD_DIGIT_W]))
                bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (state == IDLE && start)
            err_q <= bad;
    end

    assign err = err_q;
`else
    assign bad = 1'b0;
    assign err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = bad ? DONE : SUB;
            SUB:  if (last)  state_n = dig_borrow ? FIX : DONE;
            FIX:  if (last)  state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state  <= state_n;
            busy_q <= (state_n == SUB) || (state_n == FIX);
            done_q <= (state_n == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        r_q      <= '0;
                        borrow_q <= 1'b0;
                        idx_q    <= '0;
                        neg_q    <= 1'b0;
                    end
                end
                SUB, FIX: begin
                    r_q <= r_shift;
                    a_q <= a_q >> BCD_DIGIT_W;
                    b_q <= b_q >> BCD_DIGIT_W;
                    if (last) begin
                        borrow_q <= 1'b0;
                        idx_q    <= '0;
                        if (state == FIX)
                            neg_q <= 1'b1;
                    end else begin
                        borrow_q <= dig_borrow;
                        idx_q    <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = r_q;
    assign neg    = neg_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Scoreboard bench for bcd_serial_subtractor (DIGITS=4); err case under BCD_SUB_INPUT_CHECK_EN.
module tb_bcd_serial_subtractor;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b, result;
    logic         busy, done, neg, err;

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .neg    (neg),
        .err    (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] r;
        logic         neg;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 32'(result), 32'(e.r));
                chk("neg", 32'(neg), 32'(e.neg));
                chk("err", 32'(err), 32'(e.err));
                chk("done_cycle", 32'(cyc + 1), 32'(e.cyc));
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    // Issues one op, checks busy each cycle, and optionally the SUB-pass
    // intermediate; returns in the first IDLE cycle after done.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] er, input logic en, input logic ee,
                          input int lat, input logic inject, input logic [W-1:0] mid);
        a     = av;
        b     = bv;
        start = 1'b1;
        sb.push_back('{er, en, ee, cyc + 1 + lat});
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (inject && (k == 1 || k == 3)) begin
                start = 1'b1;
                a     = 16'h9999;
                b     = 16'h0000;
            end
            chk("busy", 32'(busy), 32'(k < lat - 1));
            if (lat == 2 * DIGITS + 1 && k == DIGITS)
                chk("sub_intermediate", 32'(result), 32'(mid));
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_neg", 32'(neg), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 16'h0567, 16'h0667, 1'b0, 1'b0, 5, 1'b0, 16'h0);
        run_op(16'h0567, 16'h1234, 16'h0667, 1'b1, 1'b0, 9, 1'b0, 16'h9333);
        repeat (2) @(negedge clk);
        chk("hold_result", 32'(result), 32'h0667);
        chk("hold_neg", 32'(neg), 32'd1);

        run_op(16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 5, 1'b0, 16'h0);
        // Back-to-back: start in the first cycle after done.
        run_op(16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 9, 1'b0, 16'h9999);
        run_op(16'h1234, 16'h0567, 16'h0667, 1'b0, 1'b0, 5, 1'b1, 16'h0);
        run_op(16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 5, 1'b0, 16'h0);

        // Abort mid-SUB: reset in cycle 3, no done may follow.
        a     = 16'h1234;
        b     = 16'h0567;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_neg", 32'(neg), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'h0042, 16'h0100, 16'h0058, 1'b1, 1'b0, 9, 1'b0, 16'h9942);

`ifdef BCD_SUB_INPUT_CHECK_EN
        run_op(16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 1, 1'b0, 16'h0);
        repeat (2) @(negedge clk);
        chk("err_hold", 32'(err), 32'd1);
        run_op(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 5, 1'b0, 16'h0);
`endif

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
